// File: rtl/matrix_loader_pkg.sv
// Shared types and sizes for the matrix storage loader.
// Holds the destination enum, the loader FSM state enum and the
// word/row/index widths used by the top and the row packer.
package matrix_loader_pkg;

   localparam int WORD_W        = 16;
   localparam int ROW_W         = 48;
   localparam int IDX_W         = 32;
   localparam int WORDS_PER_ROW = 3;
   localparam int WCNT_W        = 2;

   // Destination memory of a load job; the fourth encoding is rejected
   typedef enum logic [1:0] {
      TGT_INPUT  = 2'd0,
      TGT_WEIGHT = 2'd1,
      TGT_LABEL  = 2'd2
   } target_t;

   localparam logic [1:0] TGT_INVALID = 2'd3;

   // Loader sequencing: collect a row, write it, repeat, then report
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // A job asks for no rows at all when either dimension is zero
   function automatic logic isEmptyJob(input logic [IDX_W-1:0] layers,
                                       input logic [IDX_W-1:0] rows);
      return (layers == '0) || (rows == '0);
   endfunction

endpackage

// File: rtl/row_word_packer.sv
// Packs three 16-bit host words into one 48-bit storage row.
// The first word of a row ends up in the top bits, the last in the bottom.
// o_rowFull flags the cycle in which the third word of a row is accepted.
module row_word_packer
   import matrix_loader_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_accept,
   input  logic [WORD_W-1:0] i_word,
   output logic [ROW_W-1:0]  o_rowData,
   output logic              o_rowFull
);

   logic [ROW_W-1:0]  r_rowData;
   logic [WCNT_W-1:0] r_wordCount;
   logic              w_lastWord;

   assign w_lastWord = (r_wordCount == WCNT_W'(WORDS_PER_ROW - 1));
   assign o_rowFull  = i_accept && w_lastWord;
   assign o_rowData  = r_rowData;

   // Shift each accepted word in from the bottom and count words within the row
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rowData   <= '0;
         r_wordCount <= '0;
      end else if (i_clear) begin
         r_rowData   <= '0;
         r_wordCount <= '0;
      end else if (i_accept) begin
         r_rowData   <= {r_rowData[ROW_W-WORD_W-1:0], i_word};
         r_wordCount <= w_lastWord ? '0 : r_wordCount + WCNT_W'(1);
      end
   end

endmodule

// File: rtl/matrix_storage_loader.sv
// Streams host words into input/weight/label storage, one 48-bit row
// at a time, walking rows within layers for a configured job.
// Optional build macro LOADER_CHECKSUM_EN adds a 16-bit running sum of
// accepted words on port checksum; without it the port does not exist.
module matrix_storage_loader
   import matrix_loader_pkg::*;
(
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic              cfg_start,
   input  logic [1:0]        cfg_target,
   input  logic [IDX_W-1:0]  cfg_layer_count,
   input  logic [IDX_W-1:0]  cfg_rows_per_layer,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [IDX_W-1:0]  write_layer_index,
   output logic [IDX_W-1:0]  write_row_index,
   output logic [ROW_W-1:0]  write_data,
   output logic              input_is_write,
   output logic              weight_is_write,
   output logic              label_is_write,
   output logic              busy,
   output logic              done,
   output logic              cfg_error
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [WORD_W-1:0] checksum
`endif
);

   state_t           r_state;
   state_t           w_nextState;
   target_t          r_target;
   logic [IDX_W-1:0] r_layers;
   logic [IDX_W-1:0] r_rows;
   logic [IDX_W-1:0] r_layerIdx;
   logic [IDX_W-1:0] r_rowIdx;
   logic             r_done;
   logic             r_cfgError;

   logic             w_startOk;
   logic             w_startBad;
   logic             w_accept;
   logic             w_rowFull;
   logic             w_lastRow;
   logic             w_lastLayer;
   logic [ROW_W-1:0] w_rowData;

   // Only an idle loader listens to cfg_start; a busy one ignores it silently
   assign w_startOk   = (r_state == IDLE) && cfg_start && (cfg_target != TGT_INVALID);
   assign w_startBad  = (r_state == IDLE) && cfg_start && (cfg_target == TGT_INVALID);
   assign w_accept    = s_valid && s_ready;
   assign w_lastRow   = (r_rowIdx == r_rows - IDX_W'(1));
   assign w_lastLayer = (r_layerIdx == r_layers - IDX_W'(1));

   row_word_packer u_packer (
      .i_clk     (clk_clk),
      .i_rst     (reset_reset),
      .i_clear   (w_startOk),
      .i_accept  (w_accept),
      .i_word    (s_data),
      .o_rowData (w_rowData),
      .o_rowFull (w_rowFull)
   );

   // State register
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state decision: collect a row, write it, then either continue or finish
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_startOk) begin
               w_nextState = isEmptyJob(cfg_layer_count, cfg_rows_per_layer) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (w_rowFull) begin
               w_nextState = WRITE;
            end
         end
         WRITE: begin
            w_nextState = (w_lastRow && w_lastLayer) ? DONE : LOAD;
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Moore outputs: stream handshake, busy flag and the single storage strobe
   always_comb begin
      s_ready         = 1'b0;
      busy            = 1'b0;
      input_is_write  = 1'b0;
      weight_is_write = 1'b0;
      label_is_write  = 1'b0;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
         end
         LOAD: begin
            busy    = 1'b1;
            s_ready = 1'b1;
         end
         WRITE: begin
            busy = 1'b1;
            case (r_target)
               TGT_INPUT:  input_is_write  = 1'b1;
               TGT_WEIGHT: weight_is_write = 1'b1;
               TGT_LABEL:  label_is_write  = 1'b1;
               default:    input_is_write  = 1'b0;
            endcase
         end
         DONE: begin
            busy = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Latch the job on an accepted start and step row/layer after each row write
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_target   <= TGT_INPUT;
         r_layers   <= '0;
         r_rows     <= '0;
         r_layerIdx <= '0;
         r_rowIdx   <= '0;
      end else if (w_startOk) begin
         r_target   <= target_t'(cfg_target);
         r_layers   <= cfg_layer_count;
         r_rows     <= cfg_rows_per_layer;
         r_layerIdx <= '0;
         r_rowIdx   <= '0;
      end else if (r_state == WRITE) begin
         if (w_lastRow) begin
            r_rowIdx   <= '0;
            r_layerIdx <= r_layerIdx + IDX_W'(1);
         end else begin
            r_rowIdx   <= r_rowIdx + IDX_W'(1);
         end
      end
   end

   // Registered one-cycle pulses for job completion and a rejected target
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_done     <= 1'b0;
         r_cfgError <= 1'b0;
      end else begin
         r_done     <= (w_nextState == DONE);
         r_cfgError <= w_startBad;
      end
   end

   assign done              = r_done;
   assign cfg_error         = r_cfgError;
   assign write_layer_index = r_layerIdx;
   assign write_row_index   = r_rowIdx;
   assign write_data        = w_rowData;

`ifdef LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] r_checksum;

   // Wrap-around sum of every word taken from the host during the current job
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_checksum <= '0;
      end else if (w_startOk) begin
         r_checksum <= '0;
      end else if (w_accept) begin
         r_checksum <= r_checksum + s_data;
      end
   end

   assign checksum = r_checksum;
`endif

endmodule
